// File: rtl/sn74ls299.sv
// 74LS299 8-bit universal shift/storage register, pin-level model.
// The register holds bits A..H, with A as bit 0 and H as bit 7. Depending on
// the mode pins it holds, shifts right (SR enters A), shifts left (SL enters H)
// or loads from the shared I/O bus. The stored byte can be driven back onto
// that same bus. The clear input acts asynchronously.
// Ports (DIP pin numbers):
//   p12 CLK      p9  CLR_n    p1 S0     p19 S1
//   p2  OE1_n    p3  OE2_n    p11 SR    p18 SL
//   p7/p13/p6/p14/p5/p15/p4/p16  bidirectional A..H
//   p8  QA' (serial out, q[0])   p17 QH' (serial out, q[7])
module sn74ls299 (
  input  logic p12,
  input  logic p9,
  input  logic p1,
  input  logic p19,
  input  logic p2,
  input  logic p3,
  input  logic p11,
  input  logic p18,
  inout  wire  p7,
  inout  wire  p13,
  inout  wire  p6,
  inout  wire  p14,
  inout  wire  p5,
  inout  wire  p15,
  inout  wire  p4,
  inout  wire  p16,
  output logic p8,
  output logic p17
);
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic [1:0] mode;
  logic [7:0] pin_bus;
  logic [7:0] q_q, q_d;
  logic       drive_en;

  assign mode    = {p19, p1};
  assign pin_bus = {p16, p4, p15, p5, p14, p6, p13, p7};

  always_comb begin
    q_d = q_q;
    case (mode)
      HOLD:    q_d = q_q;
      SHR:     q_d = {q_q[6:0], p11};
      SHL:     q_d = {p18, q_q[7:1]};
      LOAD:    q_d = pin_bus;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge p12 or negedge p9) begin
    if (!p9) q_q <= 8'h00;
    else     q_q <= q_d;
  end

  // The load mode always releases the bus, whatever the OE pins say, so
  // an external source can present the data to be captured.
  assign drive_en = !p2 && !p3 && (mode != LOAD);

  assign p7  = drive_en ? q_q[0] : 1'bz;
  assign p13 = drive_en ? q_q[1] : 1'bz;
  assign p6  = drive_en ? q_q[2] : 1'bz;
  assign p14 = drive_en ? q_q[3] : 1'bz;
  assign p5  = drive_en ? q_q[4] : 1'bz;
  assign p15 = drive_en ? q_q[5] : 1'bz;
  assign p4  = drive_en ? q_q[6] : 1'bz;
  assign p16 = drive_en ? q_q[7] : 1'bz;

  assign p8  = q_q[0];
  assign p17 = q_q[7];
endmodule

// File: tb/tb_sn74ls299.sv
// Bench for sn74ls299: directed scenarios with literal expectations plus a
// randomized run, all compared on every falling edge against a byte-level
// model of the register. Whenever the model says the part should not be
// driving, the bench drives a known pattern itself. Any drive from the DUT in
// that window corrupts the pattern and shows up as a difference.
module tb_sn74ls299;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n, s0, s1, oe1_n, oe2_n, sr, sl;
  logic       tb_en;
  logic [7:0] drv;
  logic [7:0] ld_val;
  logic [7:0] m;          // model register
  logic       cmp_on;
  int         checks = 0;
  int         failures = 0;

  wire pa, pb, pc, pd, pe, pf, pg, ph;
  wire qa_s, qh_s;
  wire [7:0] bus = {ph, pg, pf, pe, pd, pc, pb, pa};

  assign pa = tb_en ? drv[0] : 1'bz;
  assign pb = tb_en ? drv[1] : 1'bz;
  assign pc = tb_en ? drv[2] : 1'bz;
  assign pd = tb_en ? drv[3] : 1'bz;
  assign pe = tb_en ? drv[4] : 1'bz;
  assign pf = tb_en ? drv[5] : 1'bz;
  assign pg = tb_en ? drv[6] : 1'bz;
  assign ph = tb_en ? drv[7] : 1'bz;

  sn74ls299 dut (
    .p12(clk), .p9(clr_n), .p1(s0), .p19(s1), .p2(oe1_n), .p3(oe2_n),
    .p11(sr), .p18(sl),
    .p7(pa), .p13(pb), .p6(pc), .p14(pd), .p5(pe), .p15(pf), .p4(pg), .p16(ph),
    .p8(qa_s), .p17(qh_s)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pins_enabled();
    return !oe1_n && !oe2_n && !(s1 && s0);
  endfunction

  // The bench drives the bus only while the part must be in high impedance.
  // In load mode it drives the data to be loaded. Otherwise it drives the
  // complement of the stored byte, so any stray drive from the DUT is visible.
  task automatic set_drive();
    if (pins_enabled()) begin
      tb_en = 1'b0;
      drv   = 8'h00;
    end else begin
      tb_en = 1'b1;
      drv   = (s1 && s0) ? ld_val : ~m;
    end
  endtask

  task automatic apply(input logic c, input logic [1:0] md, input logic o1,
                       input logic o2, input logic sri, input logic sli,
                       input logic [7:0] ld);
    clr_n = c; s1 = md[1]; s0 = md[0]; oe1_n = o1; oe2_n = o2;
    sr = sri; sl = sli; ld_val = ld;
    if (!c) m = 8'h00;
    set_drive();
  endtask

  // Advance one rising edge. The model is updated from the inputs held
  // across that edge, then the bench waits 1 time unit.
  task automatic tick();
    @(posedge clk);
    if (clr_n) begin
      case ({s1, s0})
        2'b01: m = (8'(m * 2)) | {7'd0, sr};
        2'b10: m = (m / 2) | (sl ? 8'h80 : 8'h00);
        2'b11: m = drv;
        default: m = m;
      endcase
    end
    set_drive();
    #1;
  endtask

  // Single compare process: serial outputs always, bus either the stored byte
  // or the bench's own undisturbed drive pattern.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_qa_ser", {7'd0, qa_s}, {7'd0, m[0]});
      chk("cmp_qh_ser", {7'd0, qh_s}, {7'd0, m[7]});
      chk("cmp_bus", bus, pins_enabled() ? m : drv);
    end
  end

  initial begin
    cmp_on = 1'b0;
    m = 8'h00;
    apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    chk("reset_model", m, 8'h00);
    chk("reset_bus", bus, 8'h00);
    chk("reset_qa", {7'd0, qa_s}, 8'h00);
    chk("reset_qh", {7'd0, qh_s}, 8'h00);
    @(posedge clk); #1;
    apply(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cmp_on = 1'b1;
    tick();

    // Load and read back
    apply(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    #1 chk("load_bus_hiz", bus, 8'h3C);
    tick();
    apply(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("load_model", m, 8'h3C);
    chk("load_readback", bus, 8'h3C);
    chk("load_qa", {7'd0, qa_s}, 8'h00);
    chk("load_qh", {7'd0, qh_s}, 8'h00);

    // Shift right
    apply(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
    tick();
    apply(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("shr_first_model", m, 8'h02);
    chk("shr_first_bus", bus, 8'h02);
    chk("shr_first_qh", {7'd0, qh_s}, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("shr_qh_after_6", {7'd0, qh_s}, 8'h01);
    end
    chk("shr_flushed", bus, 8'h00);

    // Shift left
    apply(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    tick();
    chk("shl_qa_pre", {7'd0, qa_s}, 8'h01);
    apply(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    chk("shl_1_bus", bus, 8'h80);
    chk("shl_1_qa", {7'd0, qa_s}, 8'h00);
    tick();
    chk("shl_2_model", m, 8'hC0);
    chk("shl_2_bus", bus, 8'hC0);

    // Output enables
    apply(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    tick();
    apply(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 chk("oe1_hiz", bus, 8'hA5);
    apply(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    #1 chk("oe2_hiz", bus, 8'hA5);
    apply(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 chk("oe_both_on", bus, 8'h5A);
    chk("oe_qa", {7'd0, qa_s}, 8'h00);
    chk("oe_qh", {7'd0, qh_s}, 8'h00);

    // Hold, with the serial inputs toggling
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 2'b00, 1'b0, 1'b0, k[0], ~k[0], 8'h00);
      tick();
    end
    chk("hold_bus", bus, 8'h5A);

    // Asynchronous clear mid-cycle, then an ignored load edge
    apply(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    tick();
    apply(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 chk("clr_pre_bus", bus, 8'hA5);
    apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("clr_async_bus", bus, 8'h00);
    chk("clr_async_qa", {7'd0, qa_s}, 8'h00);
    chk("clr_async_qh", {7'd0, qh_s}, 8'h00);
    apply(1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    tick();
    apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 chk("clr_edge_ignored", bus, 8'h00);
    apply(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      tick();
    end

    @(negedge clk);
    cmp_on = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
